uart_apb_stream_bridge: RTL and testbench

- APB master that sits directly upstream of the fabric UART's APB slave and exposes simple byte-stream valid/ready interfaces to fabric logic.
- After reset it programs the baud and frame configuration registers.
- It then continuously polls the status register, reads received bytes into a one-entry holding register, and writes transmit bytes whenever TXRDY is set.
- Sticky error flags collect the UART status errors and any APB slave error.

---
 rtl/uart_apb_stream_bridge_pkg.sv | 27 ++
 rtl/uart_apb_xfer.sv | 63 ++++++
 rtl/uart_apb_stream_bridge.sv | 181 ++++++++++++++++++
 tb/tb_uart_apb_stream_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_stream_bridge_pkg.sv
// Shared constants for the UART APB stream bridge: register map, STATUS bits,
// error flag positions and the sequencer state encoding.
package uart_bridge_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    localparam int ST_TXRDY    = 0;
    localparam int ST_RXRDY    = 1;
    localparam int ST_PARITY   = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_FRAMING  = 4;

    localparam int ERR_PARITY   = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_FRAMING  = 2;
    localparam int ERR_APB      = 3;

    typedef enum logic [2:0] {
        S_CFG1, S_CFG2, S_CFG3, S_POLL, S_DECIDE, S_RXRD, S_TXWR, S_GAP
    } bridge_state_e;

endpackage

// File: rtl/uart_apb_xfer.sv
// Single-transfer APB master phase engine: a start pulse while idle launches one
// SETUP/ACCESS transfer; done pulses in the cycle the slave completes it.
module uart_apb_xfer (
    input  logic       PCLK,
    input  logic       aresetn,
    input  logic       start,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    input  logic       write,
    output logic       idle,
    output logic       done,
    output logic [7:0] rdata,
    output logic       slverr,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_state_e;

    xfer_state_e state, nstate;

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) state <= X_IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            X_IDLE:   if (start) nstate = X_SETUP;
            X_SETUP:  nstate = X_ACCESS;
            X_ACCESS: if (PREADY) nstate = X_IDLE;
            default:  nstate = X_IDLE;
        endcase
    end

    // Address/data/direction are captured at launch so they stay stable through completion.
    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
        end else if (state == X_IDLE && start) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
        end
    end

    assign idle    = (state == X_IDLE);
    assign PSEL    = (state != X_IDLE);
    assign PENABLE = (state == X_ACCESS);
    assign done    = PENABLE & PREADY;
    assign rdata   = PRDATA;
    assign slverr  = done & PSLVERR;

endmodule

// File: rtl/uart_apb_stream_bridge.sv
// APB master that configures the fabric UART and then polls it, bridging bytes to
// valid/ready streams. Define UART_BRIDGE_CTRL3_EN to also program CTRL3 (BAUD_FRAC).
module uart_apb_stream_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [12:0] BAUD_VAL   = 13'd1,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0,
    parameter logic [2:0]  BAUD_FRAC  = 3'd0,
    parameter int          POLL_GAP   = 4
) (
    input  logic       PCLK,
    input  logic       aresetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic       init_done,
    output logic [3:0] err_flags,
    input  logic       err_clr
);

    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam bridge_state_e AFTER_XFER = (POLL_GAP == 0) ? S_POLL : S_GAP;
`ifdef UART_BRIDGE_CTRL3_EN
    localparam bridge_state_e LAST_CFG = S_CFG3;
`else
    localparam bridge_state_e LAST_CFG = S_CFG2;
`endif

    bridge_state_e    state, nstate;
    logic             x_start, x_write, x_idle, x_done, x_slverr;
    logic [4:0]       x_addr;
    logic [7:0]       x_wdata, x_rdata;
    logic             rxrdy_q, txrdy_q;
    logic [GAP_W-1:0] gap_cnt;

    uart_apb_xfer u_xfer (
        .PCLK    (PCLK),
        .aresetn (aresetn),
        .start   (x_start),
        .addr    (x_addr),
        .wdata   (x_wdata),
        .write   (x_write),
        .idle    (x_idle),
        .done    (x_done),
        .rdata   (x_rdata),
        .slverr  (x_slverr),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) state <= S_CFG1;
        else          state <= nstate;
    end

    // Every transfer state launches its access as soon as the engine is idle again.
    always_comb begin
        nstate  = state;
        x_start = 1'b0;
        x_addr  = ADDR_STATUS;
        x_wdata = 8'h00;
        x_write = 1'b0;
        case (state)
            S_CFG1: begin
                x_start = x_idle;
                x_addr  = ADDR_CTRL1;
                x_wdata = BAUD_VAL[7:0];
                x_write = 1'b1;
                if (x_done) nstate = S_CFG2;
            end
            S_CFG2: begin
                x_start = x_idle;
                x_addr  = ADDR_CTRL2;
                x_wdata = {BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
                x_write = 1'b1;
`ifdef UART_BRIDGE_CTRL3_EN
                if (x_done) nstate = S_CFG3;
`else
                if (x_done) nstate = S_POLL;
`endif
            end
            S_CFG3: begin
                x_start = x_idle;
                x_addr  = ADDR_CTRL3;
                x_wdata = {5'b0, BAUD_FRAC};
                x_write = 1'b1;
                if (x_done) nstate = S_POLL;
            end
            S_POLL: begin
                x_start = x_idle;
                if (x_done) nstate = S_DECIDE;
            end
            S_DECIDE: begin
                if (rxrdy_q && !rx_valid)     nstate = S_RXRD;
                else if (txrdy_q && tx_valid) nstate = S_TXWR;
                else                          nstate = AFTER_XFER;
            end
            S_RXRD: begin
                x_start = x_idle;
                x_addr  = ADDR_RXDATA;
                if (x_done) nstate = AFTER_XFER;
            end
            S_TXWR: begin
                x_start = x_idle;
                x_addr  = ADDR_TXDATA;
                x_wdata = tx_data;
                x_write = 1'b1;
                if (x_done) nstate = AFTER_XFER;
            end
            S_GAP: if (gap_cnt == GAP_LAST) nstate = S_POLL;
            default: nstate = S_CFG1;
        endcase
    end

    assign tx_ready = (state == S_TXWR) && x_done;

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn)            gap_cnt <= '0;
        else if (state != S_GAP) gap_cnt <= '0;
        else                     gap_cnt <= gap_cnt + 1'b1;
    end

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            init_done <= 1'b0;
            rxrdy_q   <= 1'b0;
            txrdy_q   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            if (state == LAST_CFG && x_done) init_done <= 1'b1;
            if (state == S_POLL && x_done) begin
                rxrdy_q <= x_rdata[ST_RXRDY];
                txrdy_q <= x_rdata[ST_TXRDY];
            end
            if (state == S_RXRD && x_done) begin
                rx_data  <= x_rdata;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Sticky error collection; a clear wins over any set in the same cycle.
    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            err_flags <= '0;
        end else if (err_clr) begin
            err_flags <= '0;
        end else begin
            if (x_slverr) err_flags[ERR_APB] <= 1'b1;
            if (state == S_POLL && x_done) begin
                err_flags[ERR_PARITY]   <= err_flags[ERR_PARITY]   | x_rdata[ST_PARITY];
                err_flags[ERR_OVERFLOW] <= err_flags[ERR_OVERFLOW] | x_rdata[ST_OVERFLOW];
                err_flags[ERR_FRAMING]  <= err_flags[ERR_FRAMING]  | x_rdata[ST_FRAMING];
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_stream_bridge.sv
// Randomized bench: APB slave model plus a transaction-level reference of the
// bridge's polling rules, error collection and rx/tx stream behaviour.
module tb_uart_apb_stream_bridge;
    import uart_bridge_pkg::*;

    localparam int GAP = 4;

    logic       PCLK = 1'b0;
    logic       aresetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic       init_done;
    logic [3:0] err_flags;
    logic       err_clr;

    always #5 PCLK = ~PCLK;

    uart_apb_stream_bridge #(
        .BAUD_VAL   (13'h1A5),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b1),
        .ODD_N_EVEN (1'b1),
        .BAUD_FRAC  (3'd5),
        .POLL_GAP   (GAP)
    ) dut (
        .PCLK      (PCLK),
        .aresetn   (aresetn),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .init_done (init_done),
        .err_flags (err_flags),
        .err_clr   (err_clr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // Expected configuration writes, from the register-map rules.
    logic [4:0] cfg_addr[$];
    logic [7:0] cfg_data[$];

    // Reference model state
    int         cfg_idx;
    bit         m_init, m_full;
    logic [3:0] m_err;
    logic [7:0] rx_q[$];
    bit         exp_known, exp_write;
    logic [4:0] exp_addr;
    logic [7:0] exp_wdata;
    bit         decide_pending, after_data, drop_tx, rst_req, arm_reset;
    logic [7:0] last_status;
    int         idle_cnt, wait_cnt;
    logic [4:0] cap_addr;
    logic [7:0] cap_wdata;
    bit         cap_write;

    task automatic expect_status();
        exp_known = 1; exp_addr = ADDR_STATUS; exp_write = 0; exp_wdata = 8'h00;
    endtask

    task automatic model_reset();
        cfg_idx = 0; m_init = 0; m_full = 0; m_err = '0; rx_q.delete();
        exp_known = 1; exp_addr = cfg_addr[0]; exp_write = 1; exp_wdata = cfg_data[0];
        decide_pending = 0; after_data = 0; drop_tx = 0; rst_req = 0;
        idle_cnt = 1; wait_cnt = 0;
        tx_valid = 0; tx_data = 8'h00; rx_ready = 0; err_clr = 0;
        PREADY = 0; PSLVERR = 0; PRDATA = 8'h00;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        model_reset();
        repeat (3) @(negedge PCLK);
        chk("rst_PSEL", PSEL, 0);
        chk("rst_PENABLE", PENABLE, 0);
        chk("rst_PWRITE", PWRITE, 0);
        chk("rst_PADDR", PADDR, 0);
        chk("rst_PWDATA", PWDATA, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_err_flags", err_flags, 0);
        aresetn = 1'b1;
    endtask

    task automatic one_cycle();
        bit         completing;
        logic [7:0] s;
        @(negedge PCLK);
        chk("init_done", init_done, m_init);
        chk("err_flags", err_flags, m_err);
        chk("rx_valid", rx_valid, m_full);

        // Cycle after a STATUS read: the bridge chooses RX first, then TX, else idles.
        if (decide_pending) begin
            decide_pending = 0;
            exp_known = 1; exp_write = 0; exp_wdata = 8'h00;
            if (last_status[ST_RXRDY] && !m_full) exp_addr = ADDR_RXDATA;
            else if (last_status[ST_TXRDY] && tx_valid) begin
                exp_addr = ADDR_TXDATA; exp_write = 1; exp_wdata = tx_data;
            end else exp_addr = ADDR_STATUS;
        end

        if (drop_tx) begin tx_valid = 0; drop_tx = 0; end
        completing = 0;
        PREADY = 0; PSLVERR = 0; PRDATA = 8'($urandom);

        if (PSEL && !PENABLE) begin
            chk("xfer_expected", exp_known, 1);
            chk("PADDR", PADDR, exp_addr);
            chk("PWRITE", PWRITE, exp_write);
            if (exp_write) chk("PWDATA", PWDATA, exp_wdata);
            if (after_data) chk("poll_gap", idle_cnt, GAP + 1);
            else            chk("psel_idle", idle_cnt >= 1, 1);
            cap_addr = PADDR; cap_wdata = PWDATA; cap_write = PWRITE;
            exp_known = 0; idle_cnt = 0;
            wait_cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            if (PADDR == ADDR_TXDATA && PWRITE && $urandom_range(0, 2) == 0) wait_cnt = 5;
            if (!tx_valid && $urandom_range(0, 3) == 0) begin
                tx_valid = 1; tx_data = 8'($urandom);
            end
        end else if (PSEL && PENABLE) begin
            chk("PADDR_stable", PADDR, cap_addr);
            chk("PWRITE_stable", PWRITE, cap_write);
            chk("PWDATA_stable", PWDATA, cap_wdata);
            if (wait_cnt > 0) begin
                if (arm_reset && cap_addr == ADDR_TXDATA && wait_cnt == 3) begin
                    #2 aresetn = 1'b0;
                    #1;
                    chk("async_rst_PSEL", PSEL, 0);
                    chk("async_rst_PENABLE", PENABLE, 0);
                    arm_reset = 0; rst_req = 1;
                    return;
                end
                wait_cnt--;
            end else begin
                PREADY = 1; completing = 1;
                PSLVERR = ($urandom_range(0, 15) == 0);
                if (cap_addr == ADDR_STATUS) begin
                    s = 8'h00;
                    s[ST_TXRDY]    = ($urandom_range(0, 1) == 0);
                    s[ST_RXRDY]    = ($urandom_range(0, 1) == 0);
                    s[ST_PARITY]   = ($urandom_range(0, 9) == 0);
                    s[ST_OVERFLOW] = ($urandom_range(0, 9) == 0);
                    s[ST_FRAMING]  = ($urandom_range(0, 9) == 0);
                    PRDATA = s;
                end
            end
        end else begin
            idle_cnt++;
        end

        err_clr  = ($urandom_range(0, 40) == 0);
        rx_ready = ($urandom_range(0, 3) == 0);
        #1;
        chk("tx_ready", tx_ready, completing && cap_addr == ADDR_TXDATA && cap_write);
        if (m_full && rx_ready) begin
            chk("rx_data", rx_data, rx_q.pop_front());
            m_full = 0;
        end

        if (completing) begin
            if (PSLVERR) m_err[ERR_APB] = 1'b1;
            after_data = 0;
            if (cap_addr == ADDR_STATUS) begin
                last_status = PRDATA;
                m_err[2:0] = m_err[2:0] | PRDATA[4:2];
                decide_pending = 1;
            end else if (cap_addr == ADDR_RXDATA) begin
                rx_q.push_back(PRDATA);
                m_full = 1; after_data = 1;
                expect_status();
            end else if (cap_addr == ADDR_TXDATA) begin
                drop_tx = 1; after_data = 1;
                expect_status();
            end else begin
                cfg_idx++;
                if (cfg_idx < cfg_addr.size()) begin
                    exp_known = 1; exp_addr = cfg_addr[cfg_idx];
                    exp_write = 1; exp_wdata = cfg_data[cfg_idx];
                end else begin
                    m_init = 1;
                    expect_status();
                end
            end
        end
        if (err_clr) m_err = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            one_cycle();
            if (rst_req) break;
        end
    endtask

    initial begin
        cfg_addr.push_back(ADDR_CTRL1); cfg_data.push_back(8'hA5);
        cfg_addr.push_back(ADDR_CTRL2); cfg_data.push_back(8'h0F);
`ifdef UART_BRIDGE_CTRL3_EN
        cfg_addr.push_back(ADDR_CTRL3); cfg_data.push_back(8'h05);
`endif
        arm_reset = 0;
        do_reset();
        run(4000);
        arm_reset = 1;
        run(20000);
        if (rst_req) do_reset();
        else chk("mid_stall_reset_reached", 0, 1);
        run(3000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
